vedic_prod_accum: RTL

Downstream consumer of the 4x4 Vedic multiplier's 8-bit product. Accepts products over a valid/ready handshake, sums a fixed batch of `N_TERMS` products into an accumulator, then emits the total least-significant byte first over a second valid/ready handshake. Turns the multiplier into a dot-product / MAC datapath inside the same TinyTapeout tile.

---
 rtl/vedic_pkg.sv | 17 +
 rtl/vedic_prod_accum_if.sv | 28 ++
 rtl/vedic_acc_adder.sv | 29 ++
 rtl/vedic_prod_accum.sv | 127 ++++++++++++
 4 files changed

// File: rtl/vedic_pkg.sv
// Shared definitions for the Vedic product accumulator.
//   state_t        : accumulator FSM states
//   BYTE_W         : width of one emitted result byte
//   DEF_*          : default parameter values for vedic_prod_accum
package vedic_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_EMIT  = 1'b1
    } state_t;

    localparam int BYTE_W      = 8;
    localparam int DEF_PROD_W  = 8;
    localparam int DEF_ACC_W   = 16;
    localparam int DEF_N_TERMS = 4;

endpackage

// File: rtl/vedic_prod_accum_if.sv
// Handshake bundle between the multiplier, the accumulator and the byte sink.
//   prod_in/prod_valid/prod_ready : product stream into the accumulator
//   out_byte/out_valid/out_ready  : result byte stream, LSB first
//   out_last                      : final (most-significant) byte marker
//   overflow                      : sticky batch overflow flag
// slave  = accumulator side, master = producer/consumer side.
interface vedic_prod_accum_if #(
    parameter int PROD_W = 8
);
    logic [PROD_W-1:0] prod_in;
    logic              prod_valid;
    logic              prod_ready;
    logic [7:0]        out_byte;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              overflow;

    modport master (
        output prod_in, prod_valid, out_ready,
        input  prod_ready, out_byte, out_valid, out_last, overflow
    );

    modport slave (
        input  prod_in, prod_valid, out_ready,
        output prod_ready, out_byte, out_valid, out_last, overflow
    );
endinterface

// File: rtl/vedic_acc_adder.sv
// Combinational accumulate step: acc + zero-extended product, ACC_W+1 bits wide.
//   acc      in  ACC_W   current accumulator
//   prod     in  PROD_W  product to add
//   acc_next out ACC_W   new accumulator value (wrapped or saturated)
//   carry    out 1       sum exceeded ACC_W bits
// Build option: VEDIC_ACC_SATURATE_EN clamps acc_next to all ones on carry;
// otherwise the sum wraps modulo 2^ACC_W.
module vedic_acc_adder #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  acc_next,
    output logic              carry
);
    logic [ACC_W:0] sum;

    assign sum   = {1'b0, acc} + (ACC_W+1)'(prod);
    assign carry = sum[ACC_W];

`ifdef VEDIC_ACC_SATURATE_EN
    // Once clamped, further adds either carry again or add zero, so the
    // accumulator stays at all ones until the batch ends.
    assign acc_next = carry ? '1 : sum[ACC_W-1:0];
`else
    assign acc_next = sum[ACC_W-1:0];
`endif
endmodule

// File: rtl/vedic_prod_accum.sv
// Batch accumulator for 8-bit Vedic multiplier products. Sums N_TERMS
// products, then emits the ACC_W-bit total LSB first, one byte per transfer.
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   ena    in  tile enable; low freezes all state and gates both handshakes
//   clear  in  synchronous batch abort (highest priority, only with ena)
//   bus    slave modport of vedic_prod_accum_if (product in, bytes out)
// Build option: VEDIC_ACC_SATURATE_EN (see vedic_acc_adder).
//
// state     | meaning
// ST_ACCUM  | accepting products, adding them into acc
// ST_EMIT   | presenting acc one byte at a time
module vedic_prod_accum
    import vedic_pkg::*;
#(
    parameter int PROD_W  = DEF_PROD_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int N_TERMS = DEF_N_TERMS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               clear,
    vedic_prod_accum_if.slave  bus
);
    localparam int ACC_BYTES = ACC_W / BYTE_W;
    localparam int IDX_W     = (ACC_BYTES > 1) ? $clog2(ACC_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ACC_BYTES - 1);
    localparam logic [7:0]       CNT_LAST = 8'(N_TERMS - 1);

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              ovf_q, ovf_d;

    logic [ACC_W-1:0]  acc_sum;
    logic              carry;
    logic              last_byte;

    vedic_acc_adder #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_adder (
        .acc      (acc_q),
        .prod     (bus.prod_in),
        .acc_next (acc_sum),
        .carry    (carry)
    );

    assign last_byte = (idx_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        ovf_d          = ovf_q;
        bus.prod_ready = 1'b0;
        bus.out_valid  = 1'b0;
        bus.out_byte   = '0;
        bus.out_last   = 1'b0;
        bus.overflow   = ovf_q;

        if (state_q == ST_ACCUM) begin
            bus.prod_ready = ena & ~clear;
        end else begin
            bus.out_valid = ena;
            bus.out_byte  = BYTE_W'(acc_q >> {idx_q, 3'b000});
            bus.out_last  = last_byte;
        end

        if (ena) begin
            if (clear) begin
                state_d = ST_ACCUM;
                acc_d   = '0;
                cnt_d   = '0;
                idx_d   = '0;
                ovf_d   = 1'b0;
            end else begin
                unique case (state_q)
                    ST_ACCUM: begin
                        if (bus.prod_valid) begin
                            acc_d = acc_sum;
                            ovf_d = ovf_q | carry;
                            cnt_d = cnt_q + 8'd1;
                            if (cnt_q == CNT_LAST) begin
                                state_d = ST_EMIT;
                                idx_d   = '0;
                            end
                        end
                    end
                    ST_EMIT: begin
                        if (bus.out_ready) begin
                            if (last_byte) begin
                                state_d = ST_ACCUM;
                                acc_d   = '0;
                                cnt_d   = '0;
                                idx_d   = '0;
                                ovf_d   = 1'b0;
                            end else begin
                                idx_d = idx_q + 1'b1;
                            end
                        end
                    end
                    default: state_d = ST_ACCUM;
                endcase
            end
        end
    end
endmodule
